lsu_align: RTL

LSU_ALIGN -- requirements
Module: lsu_align

---
 rtl/lsu_pkg.sv | 40 ++++
 rtl/lsu_lane_align.sv | 53 +++++
 rtl/lsu_align.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store alignment unit (lsu_align).
package lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE    = 2'b00,
    SIZE_HALF    = 2'b01,
    SIZE_WORD    = 2'b10,
    SIZE_ILLEGAL = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    ACC0,
    ACC1,
    RESP
  } state_e;

  localparam logic [3:0] MASK_BYTE = 4'b0001;
  localparam logic [3:0] MASK_HALF = 4'b0011;
  localparam logic [3:0] MASK_WORD = 4'b1111;

  function automatic logic [3:0] size_mask(input size_e size);
    case (size)
      SIZE_BYTE: return MASK_BYTE;
      SIZE_HALF: return MASK_HALF;
      SIZE_WORD: return MASK_WORD;
      default:   return 4'b0000;
    endcase
  endfunction

  function automatic logic [2:0] size_bytes(input size_e size);
    case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      SIZE_WORD: return 3'd4;
      default:   return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: store data/byte-enable shifting and load merge/extend.
// Second-word outputs exist only when LSU_MISALIGNED_SPLIT_EN is defined.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  off,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] word0,
`ifdef LSU_MISALIGNED_SPLIT_EN
  input  logic [31:0] word1,
  output logic [3:0]  lane1,
  output logic [31:0] wdata1,
  output logic        crossing,
`endif
  output logic [3:0]  lane0,
  output logic [31:0] wdata0,
  output logic [31:0] rdata
);

  logic [3:0]  mask;
  logic [5:0]  sh;
  logic [31:0] merged;

  assign mask   = size_mask(size);
  assign sh     = {1'b0, off, 3'b000};
  assign lane0  = mask << off;
  assign wdata0 = wdata << sh;

`ifdef LSU_MISALIGNED_SPLIT_EN
  // Shifting by a full width yields zero, so off = 0 naturally gives an empty second word.
  assign lane1    = mask >> (3'd4 - {1'b0, off});
  assign wdata1   = wdata >> (6'd32 - sh);
  assign crossing = |lane1;
  assign merged   = (word0 >> sh) | (word1 << (6'd32 - sh));
`else
  assign merged   = word0 >> sh;
`endif

  always_comb begin
    rdata = '0;
    case (size)
      SIZE_BYTE: rdata = is_unsigned ? {24'h0, merged[7:0]}
                                     : {{24{merged[7]}}, merged[7:0]};
      SIZE_HALF: rdata = is_unsigned ? {16'h0, merged[15:0]}
                                     : {{16{merged[15]}}, merged[15:0]};
      SIZE_WORD: rdata = merged;
      default:   rdata = '0;
    endcase
  end

endmodule

// File: rtl/lsu_align.sv
// Load/store alignment unit: maps byte/half/word requests onto a word-wide memory port.
// Define LSU_MISALIGNED_SPLIT_EN to split word-crossing accesses into two memory cycles.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int MEM_SIZE = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] daddr,
  output logic [31:0] dwdata,
  output logic [3:0]  we,
  input  logic [31:0] drdata
);

  state_e      state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] word0_q;
  size_e       size_q;
  logic        store_q;
  logic        unsigned_q;
  logic [3:0]  we_q;

  logic        idle;
  size_e       req_size_e;
  size_e       cur_size;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic        cur_unsigned;
  logic [31:0] word0_in;
  logic [32:0] last_byte;
  logic        req_err;

  logic [3:0]  lane0;
  logic [31:0] wdata0;
  logic [31:0] rdata;
`ifdef LSU_MISALIGNED_SPLIT_EN
  logic [3:0]  lane1;
  logic [31:0] wdata1;
  logic        crossing;
`endif

  assign idle       = (state == IDLE);
  assign req_ready  = idle;
  assign req_size_e = size_e'(req_size);

  // In IDLE the aligner looks at the live request so ACC0 outputs can be registered at acceptance.
  assign cur_size     = idle ? req_size_e   : size_q;
  assign cur_addr     = idle ? req_addr     : addr_q;
  assign cur_wdata    = idle ? req_wdata    : wdata_q;
  assign cur_unsigned = idle ? req_unsigned : unsigned_q;
  assign word0_in     = (state == ACC0) ? drdata : word0_q;

  // 33-bit sum so an access wrapping past 2^32 still lands above MEM_SIZE.
  assign last_byte = {1'b0, req_addr} + {30'b0, size_bytes(req_size_e)} - 33'd1;

  always_comb begin
    req_err = (req_size_e == SIZE_ILLEGAL) || (last_byte >= 33'(MEM_SIZE));
`ifndef LSU_MISALIGNED_SPLIT_EN
    if ((req_size_e == SIZE_HALF && req_addr[0]) ||
        (req_size_e == SIZE_WORD && req_addr[1:0] != 2'b00))
      req_err = 1'b1;
`endif
  end

  lsu_lane_align u_lane_align (
    .size        (cur_size),
    .off         (cur_addr[1:0]),
    .is_unsigned (cur_unsigned),
    .wdata       (cur_wdata),
    .word0       (word0_in),
`ifdef LSU_MISALIGNED_SPLIT_EN
    .word1       (drdata),
    .lane1       (lane1),
    .wdata1      (wdata1),
    .crossing    (crossing),
`endif
    .lane0       (lane0),
    .wdata0      (wdata0),
    .rdata       (rdata)
  );

  // Reset masks the byte enables immediately, so an abandoned access writes nothing at the reset edge.
  assign we = we_q & {4{~rst}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      daddr      <= '0;
      dwdata     <= '0;
      we_q       <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            size_q     <= req_size_e;
            store_q    <= req_we;
            unsigned_q <= req_unsigned;
            if (req_err) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state  <= ACC0;
              daddr  <= {req_addr[31:2], 2'b00};
              dwdata <= wdata0;
              we_q   <= req_we ? lane0 : 4'b0000;
            end
          end
        end
        ACC0: begin
          word0_q <= drdata;
`ifdef LSU_MISALIGNED_SPLIT_EN
          if (crossing) begin
            state  <= ACC1;
            daddr  <= {addr_q[31:2], 2'b00} + 32'd4;
            dwdata <= wdata1;
            we_q   <= store_q ? lane1 : 4'b0000;
          end else
`endif
          begin
            state      <= RESP;
            we_q       <= 4'b0000;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= store_q ? 32'h0 : rdata;
          end
        end
`ifdef LSU_MISALIGNED_SPLIT_EN
        ACC1: begin
          state      <= RESP;
          we_q       <= 4'b0000;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= store_q ? 32'h0 : rdata;
        end
`endif
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          we_q  <= 4'b0000;
        end
      endcase
    end
  end

endmodule
